// File: rtl/measurement_stream_deframer_pkg.sv
// Shared constants, state encoding and padding math for the measurement deframer
// and anything that needs to agree with its byte layout.
package measurement_stream_deframer_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_HDR,
    ST_LOAD,
    ST_HOLD
  } state_e;

  // Each round is padded up to a whole number of bytes on the wire.
  function automatic int bytes_per_round(input int pu_per_round);
    return (pu_per_round + 7) >> 3;
  endfunction

  function automatic int aligned_pu_per_round(input int pu_per_round);
    return bytes_per_round(pu_per_round) * 8;
  endfunction

endpackage

// File: rtl/measurement_unpad.sv
// Strips the per-round byte padding from an assembled volume and flags any
// padding bit that arrived set.
module measurement_unpad
  import measurement_stream_deframer_pkg::*;
#(
  parameter int PU_PER_ROUND = 42,
  parameter int ROUNDS       = 7
) (
  input  logic [aligned_pu_per_round(PU_PER_ROUND)*ROUNDS-1:0] padded_i,
  output logic [PU_PER_ROUND*ROUNDS-1:0]                       unpadded_o,
  output logic                                                 padding_nonzero_o
);

  localparam int ALIGNED = aligned_pu_per_round(PU_PER_ROUND);
  localparam int PAD_W   = ALIGNED - PU_PER_ROUND;

  logic [ROUNDS-1:0] pad_bits;

  for (genvar r = 0; r < ROUNDS; r++) begin : g_round
    assign unpadded_o[r*PU_PER_ROUND +: PU_PER_ROUND] = padded_i[r*ALIGNED +: PU_PER_ROUND];
    if (PAD_W > 0) begin : g_pad
      assign pad_bits[r] = |padded_i[r*ALIGNED+PU_PER_ROUND +: PAD_W];
    end else begin : g_no_pad
      assign pad_bits[r] = 1'b0;
    end
  end

  assign padding_nonzero_o = |pad_bits;

endmodule

// File: rtl/measurement_stream_deframer.sv
// Receive-side deframer: collects one padded syndrome volume from the host byte
// stream, unpads it and presents it to the decoder over valid/ready.
module measurement_stream_deframer
  import measurement_stream_deframer_pkg::*;
#(
  parameter int GRID_WIDTH_X = 7,
  parameter int GRID_WIDTH_Z = 6,
  parameter int GRID_WIDTH_U = 7
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [7:0]                                    input_data,
  input  logic                                          input_valid,
  output logic                                          input_ready,
  output logic [GRID_WIDTH_X*GRID_WIDTH_Z*GRID_WIDTH_U-1:0] measurements,
  output logic                                          measurements_valid,
  input  logic                                          measurements_ready,
  output logic                                          decoding_active,
  output logic                                          frame_error
);

  localparam int PU_PER_ROUND    = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int BYTES_PER_ROUND = bytes_per_round(PU_PER_ROUND);
  localparam int TOTAL_BYTES     = BYTES_PER_ROUND * GRID_WIDTH_U;
  localparam int BUF_W           = TOTAL_BYTES * 8;
  localparam int MEAS_W          = PU_PER_ROUND * GRID_WIDTH_U;
  localparam int CNT_W           = $clog2(TOTAL_BYTES + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [MEAS_W-1:0]  meas_q, unpadded_d;
  logic               in_ready_q, meas_valid_q, active_q, ferr_q;
  logic               pad_nonzero_d;
  logic               accept;

  assign accept = input_valid & in_ready_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    buf_d = buf_q;
    if (accept && state_q == ST_WAIT_HDR && input_data == MEASUREMENT_DATA_HEADER) begin
      buf_d = '0;
    end else if (accept && state_q == ST_LOAD) begin
      for (int n = 0; n < TOTAL_BYTES; n++) begin
        if (cnt_q == CNT_W'(n)) buf_d[n*8 +: 8] = input_data;
      end
    end
  end

  // Unpadding looks at the next buffer so the padding check sees the final byte on HOLD entry.
  measurement_unpad #(
    .PU_PER_ROUND(PU_PER_ROUND),
    .ROUNDS      (GRID_WIDTH_U)
  ) u_unpad (
    .padded_i         (buf_d),
    .unpadded_o       (unpadded_d),
    .padding_nonzero_o(pad_nonzero_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      // NOTE: the volume buffer is reset because measurements must read zero out of reset.
      buf_q        <= '0;
      meas_q       <= '0;
      in_ready_q   <= 1'b0;
      meas_valid_q <= 1'b0;
      active_q     <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      meas_q <= unpadded_d;
      ferr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (input_data == START_DECODING_MSG) begin
              state_q  <= ST_WAIT_HDR;
              active_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end
        end
        ST_WAIT_HDR: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (input_data == MEASUREMENT_DATA_HEADER) begin
              state_q <= ST_LOAD;
              cnt_q   <= '0;
            end else if (input_data != START_DECODING_MSG) begin
              ferr_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TOTAL_BYTES - 1)) begin
              state_q      <= ST_HOLD;
              in_ready_q   <= 1'b0;
              meas_valid_q <= 1'b1;
              ferr_q       <= pad_nonzero_d;
            end
          end
        end
        ST_HOLD: begin
          if (meas_valid_q && measurements_ready) begin
            state_q      <= ST_WAIT_HDR;
            meas_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign input_ready        = in_ready_q;
  assign measurements       = meas_q;
  assign measurements_valid = meas_valid_q;
  assign decoding_active    = active_q;
  assign frame_error        = ferr_q;

endmodule
